tile_diff_scanner: RTL
======================

# tile_diff_scanner

Parametrised grid scanner for the snake display pipeline. It walks every cell of a GRID_W x GRID_H tile map and priority-encodes the object request inputs into an object code. It compares that code against an internal shadow map and stops on each changed cell until the display command engine acknowledges the redraw. It replaces the fixed 16x12, four-object scanner with configurable grid size, object count, forced full-redraw and per-frame change reporting.

## Interface
Parameters:
- GRID_W, 16, number of columns (x range 0..GRID_W-1), 2..16
- GRID_H, 12, number of rows (y range 0..GRID_H-1), 2..16
- N_OBJ, 4, number of object request inputs, 1..7
- CODE_W, 3, object code width; must hold N_OBJ (code 0 = empty)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous clear, same effect as reset
- obj_req  in  N_OBJ  object hits for current (x,y); bit 0 highest priority
- redraw  in  1  request full redraw of next frame
- cmd_done  in  1  display engine finished current cell
- x  out  4  current column
- y  out  4  current row
- obj_code  out  CODE_W  code of the cell being redrawn
- diff  out  1  cell changed, redraw pending
- init_cycle  out  1  current frame is a full redraw
- en_update  out  1  one-cycle pulse: frame finished with at least one change
- frame_done  out  1  one-cycle pulse at end of every frame
- diff_count  out  8  changed cells in last frame (see Configuration)

## Operation
- Encoding: code = i+1 for the lowest set bit i of obj_req; code = 0 if obj_req == 0.
- Shadow map: GRID_W*GRID_H entries of CODE_W bits. Reset/sync_reset clears all entries to 0.
- Scan order: x increments first. At x=GRID_W-1, x wraps to 0 and y increments. The cell after (GRID_W-1, GRID_H-1) ends the frame.
- States:
  - SCAN: compare code with map[x][y].
    - If they differ, or init_cycle=1: write map, load obj_code, set diff, go to WAIT. x,y are held.
    - Otherwise advance one cell.
    - On the last cell, a no-change result goes to DONE.
  - WAIT: x, y, obj_code and diff are held. On cmd_done=1: clear diff and advance, going to DONE if this was the last cell, else SCAN. cmd_done is ignored in SCAN and DONE.
  - DONE: one cycle.
    - Pulse frame_done.
    - Pulse en_update if any cell changed this frame.
    - Set x=y=0.
    - Load init_cycle from the latched redraw request, which clears it unless a redraw is latched.
    - Return to SCAN.
- redraw: a pulse at any time is latched. The next DONE sets init_cycle=1 for the whole following frame.
- Reset values:
  - state=SCAN, x=0, y=0, obj_code=0
  - diff=0, init_cycle=1, en_update=0, frame_done=0
  - diff_count=0, redraw latch=0
- sync_reset overrides every other input in the cycle it is sampled, including mid-WAIT.

## Timing
- Upstream decodes obj_req combinationally from the registered x,y. The scanner samples obj_req in the same cycle.
- Unchanged cell: exactly 1 cycle per cell.
- Changed cell:
  - diff rises the cycle after detection.
  - cmd_done is sampled on rising edge t; diff falls and x,y advance at t.
  - Total cost is 2 cycles plus the acknowledge wait.
- Frame with no changes: GRID_W*GRID_H + 1 cycles (default 193).
- cmd_done held high for several cycles acknowledges only the current WAIT. A new WAIT needs cmd_done seen low first.
- All outputs are registered.

## Configuration
- TILE_DIFF_COUNT_EN defined:
  - An 8-bit saturating counter counts transitions into WAIT within a frame.
  - It is copied to diff_count in DONE, then cleared.
- TILE_DIFF_COUNT_EN undefined:
  - The counter is not built.
  - diff_count is tied to 0.

## Test plan
- Reset, no stimulus → x=0, y=0, init_cycle=1, diff=0. The first SCAN cycle raises diff with obj_code=0 at (0,0).
- First frame with border at x∈{0,15} or y∈{0,11}, head (bit 1) at (4,4), apple at (7,4), cmd_done 5 cycles after each diff → 192 diffs.
  - obj_code=2 at (4,4) with border bit clear.
  - en_update pulses once; init_cycle falls after DONE.
  - diff_count=192 when TILE_DIFF_COUNT_EN is defined; saturation applies only above 255.
- Second identical frame → no diff, frame_done after 193 cycles, en_update=0, diff_count=0.
- Move head to (5,4) → diffs exactly at (4,4) with code 0 and (5,4) with code 2; diff_count=2.
- obj_req=4'b0011 at one cell → obj_code=1 (bit 0 wins).
- Pulse redraw mid-frame, then sync_reset during WAIT → next cycle x=y=0, diff=0, init_cycle=1, shadow map cleared, redraw latch cleared.

Source files
------------

// File: rtl/tile_diff_scanner.sv
// Grid scanner: walks the tile map, priority-encodes obj_req and stalls on every cell whose
// code differs from the shadow map until the display engine acknowledges. Define TILE_DIFF_COUNT_EN for diff_count.
module tile_diff_scanner #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int N_OBJ  = 4,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sync_reset,
  input  logic [N_OBJ-1:0]  obj_req,
  input  logic              redraw,
  input  logic              cmd_done,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic [CODE_W-1:0] obj_code,
  output logic              diff,
  output logic              init_cycle,
  output logic              en_update,
  output logic              frame_done,
  output logic [7:0]        diff_count
);

  typedef enum logic [1:0] {SCAN, WAIT, DONE} state_t;

  localparam int MAP_N = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(MAP_N);
  localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

  state_t state, next_state;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] shadow [MAP_N];
  logic [IDX_W-1:0]  cell_idx;
  logic cell_changed, last_cell, ack;
  logic ack_lock, redraw_latch, frame_changed;
  logic capture, advance, finish;

  // Lowest set request bit wins; code 0 means an empty cell.
  always_comb begin
    code = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (obj_req[i]) code = CODE_W'(i + 1);
    end
  end

  assign cell_idx     = IDX_W'(int'(y) * GRID_W + int'(x));
  assign cell_changed = (code != shadow[cell_idx]) || init_cycle;
  assign last_cell    = (x == X_LAST) && (y == Y_LAST);
  // A held-high cmd_done may acknowledge only one WAIT; it must drop before the next one.
  assign ack          = cmd_done && !ack_lock;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)           state <= SCAN;
    else if (sync_reset) state <= SCAN;
    else                 state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SCAN: begin
        if (cell_changed)   next_state = WAIT;
        else if (last_cell) next_state = DONE;
      end
      WAIT: if (ack) next_state = last_cell ? DONE : SCAN;
      DONE: next_state = SCAN;
      default: next_state = SCAN;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state)
      SCAN: begin
        capture = cell_changed;
        advance = !cell_changed;
      end
      WAIT: advance = ack;
      DONE: finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x <= '0; y <= '0; obj_code <= '0; diff <= 1'b0;
      init_cycle <= 1'b1; en_update <= 1'b0; frame_done <= 1'b0;
      ack_lock <= 1'b0; redraw_latch <= 1'b0; frame_changed <= 1'b0;
      for (int i = 0; i < MAP_N; i++) shadow[i] <= '0;
    end else if (sync_reset) begin
      x <= '0; y <= '0; obj_code <= '0; diff <= 1'b0;
      init_cycle <= 1'b1; en_update <= 1'b0; frame_done <= 1'b0;
      ack_lock <= 1'b0; redraw_latch <= 1'b0; frame_changed <= 1'b0;
      for (int i = 0; i < MAP_N; i++) shadow[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      en_update  <= 1'b0;
      if (!cmd_done) ack_lock <= 1'b0;
      if (redraw) redraw_latch <= 1'b1;
      if (capture) begin
        shadow[cell_idx] <= code;
        obj_code         <= code;
        diff             <= 1'b1;
        frame_changed    <= 1'b1;
      end
      if (advance) begin
        diff <= 1'b0;
        if (state == WAIT) ack_lock <= 1'b1;
        if (!last_cell) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= y + 4'd1;
          end else begin
            x <= x + 4'd1;
          end
        end
      end
      // End of frame: rewind and arm the next frame's full-redraw flag.
      if (finish) begin
        frame_done    <= 1'b1;
        en_update     <= frame_changed;
        x             <= '0;
        y             <= '0;
        init_cycle    <= redraw_latch | redraw;
        redraw_latch  <= 1'b0;
        frame_changed <= 1'b0;
      end
    end
  end

`ifdef TILE_DIFF_COUNT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt   <= '0;
      diff_count <= '0;
    end else if (sync_reset) begin
      wait_cnt   <= '0;
      diff_count <= '0;
    end else if (finish) begin
      diff_count <= wait_cnt;
      wait_cnt   <= '0;
    end else if (capture && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign diff_count = '0;
`endif

endmodule
